// File: rtl/piece_controller.sv
// Active-tetromino sequencer: turns tick/move requests into collision-checker runs,
// updates the anchor, locks landed pieces into board RAM and hands off to line clear.
module piece_controller #(
    parameter logic [4:0]  SPAWN_X = 5'd4,
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 24,
    parameter logic [3:0]  WDOG    = 4'd8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       game_start,
    input  logic       tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic [3:0] next_block,
    input  logic [7:0] cell_x,
    input  logic [7:0] cell_y,
    input  logic [5:0] lock_colour,
    output logic       chk_enable,
    output logic       chk_left,
    output logic       chk_right,
    input  logic       chk_complete,
    input  logic       chk_collision,
    input  logic [4:0] chk_x,
    input  logic [5:0] chk_y,
    output logic [4:0] x_anchor,
    output logic [5:0] y_anchor,
    output logic [3:0] block,
    output logic [1:0] ram_sel,
    output logic [7:0] ram_addr,
    output logic [5:0] ram_data,
    output logic       ram_wren,
    output logic       lines_req,
    input  logic       lines_done,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE, SPAWN, WAIT, PREP, CHECK, LOCK, CLEAR, GAME_OVER
    } state_t;

    state_t      state_q, state_d;
    logic        pl_q, pl_d, pr_q, pr_d, pt_q, pt_d;
    logic        left_q, left_d, right_q, right_d;
    logic [4:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [3:0]  block_q, block_d;
    logic [3:0]  wdog_q, wdog_d;
    logic [1:0]  lidx_q, lidx_d;
    logic [7:0]  addr_q, addr_d;
    logic [5:0]  data_q, data_d;
    logic        wren_q, wren_d;

    logic        clr_l, clr_r, clr_t, clr_all, load_lock, set_en;
    logic [1:0]  lidx_n, cx_sel, cy_sel;
    logic [6:0]  row;
    logic [7:0]  addr_n;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        block_d   = block_q;
        left_d    = left_q;
        right_d   = right_q;
        wdog_d    = wdog_q;
        lidx_d    = lidx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        clr_l     = 1'b0;
        clr_r     = 1'b0;
        clr_t     = 1'b0;
        clr_all   = 1'b0;
        load_lock = 1'b0;
        lidx_n    = 2'd0;

        case (state_q)
            IDLE: if (game_start) state_d = SPAWN;
            SPAWN: begin
                block_d = next_block;
                x_d     = SPAWN_X;
                y_d     = 6'd0;
                clr_all = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // Contradictory left+right cancel each other; a pending tick still runs.
                if (pl_q && pr_q) begin
                    clr_l = 1'b1;
                    clr_r = 1'b1;
                    if (pt_q) begin
                        clr_t = 1'b1; left_d = 1'b0; right_d = 1'b0; state_d = PREP;
                    end
                end else if (pl_q) begin
                    clr_l = 1'b1; left_d = 1'b1; right_d = 1'b0; state_d = PREP;
                end else if (pr_q) begin
                    clr_r = 1'b1; left_d = 1'b0; right_d = 1'b1; state_d = PREP;
                end else if (pt_q) begin
                    clr_t = 1'b1; left_d = 1'b0; right_d = 1'b0; state_d = PREP;
                end
            end
            PREP: begin
                wdog_d  = 4'd0;
                state_d = CHECK;
            end
            CHECK: begin
                if (chk_complete) begin
                    left_d  = 1'b0;
                    right_d = 1'b0;
                    if (left_q || right_q) begin
                        x_d     = chk_x;
                        state_d = WAIT;
                    end else if (chk_collision) begin
                        lidx_d    = 2'd0;
                        load_lock = 1'b1;
                        state_d   = LOCK;
                    end else begin
                        y_d     = chk_y;
                        state_d = WAIT;
                    end
                end else if (wdog_q == WDOG - 4'd1) begin
                    left_d  = 1'b0;
                    right_d = 1'b0;
                    state_d = WAIT;
                end else begin
                    wdog_d = wdog_q + 4'd1;
                end
            end
            LOCK: begin
                if (lidx_q == 2'd3) begin
                    state_d = (y_q == 6'd0) ? GAME_OVER : CLEAR;
                end else begin
                    lidx_d    = lidx_q + 2'd1;
                    lidx_n    = lidx_q + 2'd1;
                    load_lock = 1'b1;
                end
            end
            CLEAR:     if (lines_done) state_d = SPAWN;
            GAME_OVER: if (game_start) state_d = SPAWN;
            default:   state_d = IDLE;
        endcase

        // Address is prepared one cycle early so addr/data/wren line up in the LOCK cycle.
        // Modulo-256 arithmetic gives the low byte of the 9-bit address directly.
        cx_sel = cell_x[{lidx_n, 1'b0} +: 2];
        cy_sel = cell_y[{lidx_n, 1'b0} +: 2];
        row    = {1'b0, y_q} + {5'd0, cy_sel};
        addr_n = {1'b0, row} * 8'(BOARD_W) + {3'd0, x_q} + {6'd0, cx_sel};
        if (load_lock) begin
            addr_d = addr_n;
            data_d = lock_colour;
            wren_d = (row < 7'(BOARD_H));
        end
    end

    assign set_en = (state_q != IDLE) && (state_q != GAME_OVER);
    // A pulse coinciding with its flag's service is kept, so no request is lost.
    assign pl_d = !clr_all && ((pl_q && !clr_l) || (set_en && move_left));
    assign pr_d = !clr_all && ((pr_q && !clr_r) || (set_en && move_right));
    assign pt_d = !clr_all && ((pt_q && !clr_t) || (set_en && tick));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            pl_q    <= 1'b0;
            pr_q    <= 1'b0;
            pt_q    <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            x_q     <= 5'd0;
            y_q     <= 6'd0;
            block_q <= 4'd0;
            wdog_q  <= 4'd0;
            lidx_q  <= 2'd0;
            addr_q  <= 8'd0;
            data_q  <= 6'd0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            pt_q    <= pt_d;
            left_q  <= left_d;
            right_q <= right_d;
            x_q     <= x_d;
            y_q     <= y_d;
            block_q <= block_d;
            wdog_q  <= wdog_d;
            lidx_q  <= lidx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
        end
    end

    assign chk_enable = (state_q == CHECK);
    assign chk_left   = left_q;
    assign chk_right  = right_q;
    assign x_anchor   = x_q;
    assign y_anchor   = y_q;
    assign block      = block_q;
    assign ram_sel    = (state_q == LOCK)  ? 2'b01 :
                        (state_q == CLEAR) ? 2'b10 : 2'b00;
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;
    assign ram_wren   = wren_q;
    assign lines_req  = (state_q == CLEAR);
    assign busy       = (state_q != IDLE) && (state_q != WAIT) && (state_q != GAME_OVER);
    assign game_over  = (state_q == GAME_OVER);

endmodule
